// File: rtl/sdp_bram_bw_fwd_if.sv
// Port bundle for the simple-dual-port RAM: write port A, read port B, clear status.
// The master side drives requests and the slave (RAM) side returns read data.
interface sdp_bram_bw_fwd_if #(
    parameter int LEN_DATA = 32,
    parameter int LEN_ADDR = 8
);
    logic                  ena;
    logic [LEN_DATA/8-1:0] wea;
    logic [LEN_ADDR-1:0]   addra;
    logic [LEN_DATA-1:0]   dina;
    logic                  enb;
    logic [LEN_ADDR-1:0]   addrb;
    logic [LEN_DATA-1:0]   doutb;
    logic                  doutb_valid;
    logic                  init_busy;

    modport master (
        output ena, wea, addra, dina, enb, addrb,
        input  doutb, doutb_valid, init_busy
    );
    modport slave (
        input  ena, wea, addra, dina, enb, addrb,
        output doutb, doutb_valid, init_busy
    );
endinterface

// File: rtl/sdp_bram_bw_fwd.sv
// Single-clock SDP RAM with byte enables, write-first collision forwarding,
// optional output register and a post-reset clear engine that zeroes every word.
module sdp_bram_bw_fwd #(
    parameter int LEN_DATA = 32,
    parameter int LEN_ADDR = 8,
    parameter bit OUT_REG  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    sdp_bram_bw_fwd_if.slave bus
);
    localparam int DEPTH  = 2 ** LEN_ADDR;
    localparam int NBYTE  = LEN_DATA / 8;
    localparam int STAGES = OUT_REG ? 2 : 1;

    typedef enum logic {CLEAR, READY} state_e;

    state_e              state_q, state_d;
    logic [LEN_ADDR-1:0] cnt_q, cnt_d;
    logic                clr_we, wr_en, rd_en;
    logic [LEN_DATA-1:0] mem [DEPTH];
    logic [LEN_DATA-1:0] rd_word;
    logic [LEN_DATA-1:0] rdata_q;
    logic [STAGES:1]     vld_pipe_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = !rst;
                cnt_d  = cnt_q + 1'b1;
                if (&cnt_q) state_d = READY;
            end
            READY: begin
                wr_en = !rst && bus.ena;
                rd_en = !rst && bus.enb;
            end
            default: state_d = CLEAR;
        endcase
    end

    assign bus.init_busy = (state_q == CLEAR);

    // Write-first per byte: a same-cycle write to the read address overrides old bytes.
    always_comb begin
        rd_word = mem[bus.addrb];
        for (int i = 0; i < NBYTE; i++)
            if (bus.ena && bus.wea[i] && (bus.addra == bus.addrb))
                rd_word[8*i +: 8] = bus.dina[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NBYTE; i++)
                if (bus.wea[i]) mem[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q    <= '0;
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[1] <= rd_en;
            for (int s = 2; s <= STAGES; s++) vld_pipe_q[s] <= vld_pipe_q[s-1];
            if (rd_en) rdata_q <= rd_word;
        end
    end

    generate
        if (OUT_REG) begin : g_oreg
            logic [LEN_DATA-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst)                dout_q <= '0;
                else if (vld_pipe_q[1]) dout_q <= rdata_q;
            end
            assign bus.doutb = dout_q;
        end else begin : g_noreg
            assign bus.doutb = rdata_q;
        end
    endgenerate

    assign bus.doutb_valid = vld_pipe_q[STAGES];
endmodule

// File: tb/tb_sdp_bram_bw_fwd.sv
// Drives identical traffic into an OUT_REG=0 and an OUT_REG=1 instance and scoreboards
// both against a word-array model of the RAM with a per-read due-cycle queue.
module tb_sdp_bram_bw_fwd;
    localparam int LD    = 32;
    localparam int LA    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        logic [LD-1:0] data;
        int            due;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          ena, enb;
    logic [3:0]    wea;
    logic [LA-1:0] addra, addrb;
    logic [LD-1:0] dina;

    int            vectors = 0;
    int            errors  = 0;
    int            edge_cnt = 0;
    int            clear_left = 0;
    bit            started = 0;
    logic [LD-1:0] mem_m [DEPTH];
    exp_t          expq [2][$];
    logic [LD-1:0] hold [2];

    sdp_bram_bw_fwd_if #(.LEN_DATA(LD), .LEN_ADDR(LA)) if0 ();
    sdp_bram_bw_fwd_if #(.LEN_DATA(LD), .LEN_ADDR(LA)) if1 ();

    assign if0.ena = ena;   assign if1.ena = ena;
    assign if0.wea = wea;   assign if1.wea = wea;
    assign if0.addra = addra; assign if1.addra = addra;
    assign if0.dina = dina; assign if1.dina = dina;
    assign if0.enb = enb;   assign if1.enb = enb;
    assign if0.addrb = addrb; assign if1.addrb = addrb;

    sdp_bram_bw_fwd #(.LEN_DATA(LD), .LEN_ADDR(LA), .OUT_REG(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0));
    sdp_bram_bw_fwd #(.LEN_DATA(LD), .LEN_ADDR(LA), .OUT_REG(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LD-1:0] act, input logic [LD-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %h expected %h", name, edge_cnt, act, exp);
        end
    endtask

    // One clock edge: apply the RAM rules to the inputs held across it.
    task automatic tick();
        logic [LD-1:0] w;
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            clear_left = DEPTH;
            for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
            for (int k = 0; k < 2; k++) begin
                expq[k].delete();
                hold[k] = '0;
            end
            started = 1;
        end else if (clear_left > 0) begin
            clear_left--;
        end else begin
            if (enb) begin
                w = mem_m[addrb];
                for (int i = 0; i < 4; i++)
                    if (ena && wea[i] && addra == addrb) w[8*i +: 8] = dina[8*i +: 8];
                for (int k = 0; k < 2; k++) expq[k].push_back('{data: w, due: edge_cnt + k});
            end
            if (ena)
                for (int i = 0; i < 4; i++)
                    if (wea[i]) mem_m[addra][8*i +: 8] = dina[8*i +: 8];
        end
        @(negedge clk);
    endtask

    task automatic mon(input int k, input logic v, input logic [LD-1:0] d, input logic b);
        bit   exp_v;
        exp_t e;
        chk($sformatf("init_busy[%0d]", k), {31'd0, b}, {31'd0, clear_left > 0});
        exp_v = (expq[k].size() > 0) && (expq[k][0].due == edge_cnt);
        chk($sformatf("doutb_valid[%0d]", k), {31'd0, v}, {31'd0, exp_v});
        if (exp_v) begin
            e = expq[k].pop_front();
            if (v) chk($sformatf("doutb[%0d]", k), d, e.data);
            hold[k] = e.data;
        end else begin
            chk($sformatf("doutb_hold[%0d]", k), d, hold[k]);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            mon(0, if0.doutb_valid, if0.doutb, if0.init_busy);
            mon(1, if1.doutb_valid, if1.doutb, if1.init_busy);
        end
    end

    task automatic idle(input int n);
        ena = 0; enb = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [LA-1:0] a, input logic [LD-1:0] d, input logic [3:0] w);
        ena = 1; enb = 0; addra = a; dina = d; wea = w;
        tick();
        ena = 0;
    endtask

    task automatic rd(input logic [LA-1:0] a);
        enb = 1; ena = 0; addrb = a;
        tick();
        enb = 0;
    endtask

    initial begin
        rst = 1; ena = 0; enb = 1; wea = '0; addra = '0; addrb = 4'd5; dina = '0;
        // Reset and clear with a read request held on address 5 throughout.
        for (int i = 0; i < 3; i++) tick();
        rst = 0;
        for (int i = 0; i < DEPTH; i++) tick();
        for (int a = 0; a < DEPTH; a++) rd(LA'(a));
        idle(2);

        // Byte-masked write.
        wr(4'd3, 32'hAABBCCDD, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd(4'd3);
        chk("masked_dout0", if0.doutb, 32'hAA22CC44);
        idle(1);
        chk("masked_dout1", if1.doutb, 32'hAA22CC44);

        // Collision forwarding.
        wr(4'd7, 32'h01020304, 4'b1111);
        ena = 1; addra = 4'd7; dina = 32'hF0F0F0F0; wea = 4'b1001; enb = 1; addrb = 4'd7;
        tick();
        ena = 0; enb = 0;
        chk("collide_dout0", if0.doutb, 32'hF00203F0);
        idle(1);
        chk("collide_dout1", if1.doutb, 32'hF00203F0);
        rd(4'd7);
        idle(2);

        // Streaming reads.
        for (int a = 0; a < 8; a++) wr(LA'(a), 32'h11111111 * a, 4'b1111);
        for (int a = 0; a < 8; a++) rd(LA'(a));
        idle(3);
        chk("stream_hold0", if0.doutb, 32'h77777777);
        chk("stream_hold1", if1.doutb, 32'h77777777);

        // Reset in the middle of the clear.
        wr(4'd2, 32'hDEADBEEF, 4'b1111);
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1; tick(); rst = 0;
        for (int i = 0; i < DEPTH; i++) tick();
        rd(4'd2);
        idle(2);
        chk("midclr_data0", if0.doutb, 32'h0);

        // Reset in READY right behind a read.
        wr(4'd3, 32'h12345678, 4'b1111);
        rd(4'd3);
        rst = 1; tick(); rst = 0;
        chk("rdyrst_dout1", if1.doutb, 32'h0);
        idle(DEPTH + 2);

        // Random traffic, including port activity during the clear and rare resets.
        for (int n = 0; n < 3000; n++) begin
            rst   = ($urandom_range(0, 199) == 0);
            ena   = $urandom_range(0, 1);
            enb   = $urandom_range(0, 1);
            wea   = 4'($urandom);
            addra = LA'($urandom_range(0, 3) == 0 ? addrb : 4'($urandom));
            addrb = 4'($urandom);
            dina  = $urandom;
            tick();
        end
        rst = 0;
        idle(4);
        chk("q0_drained", 32'(expq[0].size()), 32'd0);
        chk("q1_drained", 32'(expq[1].size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
